// File: rtl/float_pkg.sv
// Shared constants, unpacked-float type and FSM encoding for the float_acc
// accumulator datapath.
package float_pkg;

    localparam int E       = 8;
    localparam int M       = 23;
    localparam int G       = 3;
    localparam int Width   = 1 + E + M;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    // Aligned operand field and raw sum field (one extra bit for carry out).
    localparam int ALN_W = M + 1 + G;
    localparam int SUM_W = M + 2 + G;
    localparam int LZ_W  = $clog2(SUM_W + 1);

    typedef struct packed {
        logic         sign;
        logic [E-1:0] exp;
        logic [M:0]   mant;
    } ufloat_t;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        OUT
    } state_t;

    // Zero exponent flushes to zero: no denormals anywhere in this datapath.
    function automatic ufloat_t unpack(input logic [Width-1:0] f);
        ufloat_t u;
        u.sign = f[Width-1];
        u.exp  = f[Width-2:M];
        u.mant = (u.exp == '0) ? '0 : {1'b1, f[M-1:0]};
        return u;
    endfunction

endpackage

// File: rtl/float_acc_lzc.sv
// Leading-zero counter over the raw sum field; an all-zero input yields SUM_W.
module float_acc_lzc
    import float_pkg::*;
(
    input  logic [SUM_W-1:0] value,
    output logic [LZ_W-1:0]  count
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        count = LZ_W'(SUM_W);
        for (int i = 0; i < SUM_W; i++) begin
            if (value[i]) begin
                count = LZ_W'(SUM_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/float_acc.sv
// Sequential single-precision accumulator: one operand per 4 cycles, frame sum
// emitted after the operand flagged last. FLOAT_ACC_FLAGS_EN adds sticky {ovf, unf} flags.
module float_acc
    import float_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data
`ifdef FLOAT_ACC_FLAGS_EN
    ,
    output logic [1:0]       flags
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the sender holds data stable until then, ready never waits on valid.

    state_t           state, state_next;
    logic [Width-1:0] op_q, acc_q;
    logic             last_q, first_q;
    logic             a_sign_q, sub_q, inf_q, inf_sign_q;
    logic [E-1:0]     a_exp_q;
    logic [M:0]       a_mant_q;
    logic [ALN_W-1:0] b_mant_q;
    logic [SUM_W-1:0] sum_q;

    ufloat_t          op_u, acc_u, a_u, b_u;
    logic             op_bigger, op_inf, acc_inf, inf_sign;
    logic [E-1:0]     exp_diff;
    logic [ALN_W-1:0] b_aligned;

    always_comb begin
        op_u      = unpack(op_q);
        acc_u     = first_q ? '0 : unpack(acc_q);
        op_inf    = &op_q[Width-2:M];
        acc_inf   = !first_q && (&acc_q[Width-2:M]);
        op_bigger = {op_u.exp, op_u.mant} > {acc_u.exp, acc_u.mant};
        a_u       = op_bigger ? op_u : acc_u;
        b_u       = op_bigger ? acc_u : op_u;
        exp_diff  = a_u.exp - b_u.exp;
        b_aligned = {b_u.mant, {G{1'b0}}} >> exp_diff;
        // Opposite-sign infinities resolve to +inf; no NaN is ever produced.
        inf_sign  = op_inf ? (op_q[Width-1] & ~(acc_inf & (acc_q[Width-1] != op_q[Width-1])))
                           : acc_q[Width-1];
    end

    logic [LZ_W-1:0]  lz;
    logic [E+1:0]     exp_n;
    logic [SUM_W-1:0] norm_mag;
    logic [M-1:0]     mant_n;
    logic [Width-1:0] norm_res;
    logic             norm_ovf, norm_unf;

    float_acc_lzc u_lzc (
        .value (sum_q),
        .count (lz)
    );

    always_comb begin
        norm_ovf = 1'b0;
        norm_unf = 1'b0;
        if (sum_q[SUM_W-1]) begin
            norm_mag = sum_q >> 1;
            exp_n    = {2'b00, a_exp_q} + (E+2)'(1);
        end else begin
            norm_mag = sum_q << (lz - 1'b1);
            exp_n    = {2'b00, a_exp_q} + (E+2)'(1) - (E+2)'(lz);
        end
        // Guard bits fall off here: round toward zero.
        mant_n = M'(norm_mag >> G);
        if (inf_q) begin
            norm_res = {inf_sign_q, {E{1'b1}}, {M{1'b0}}};
        end else if (sum_q == '0) begin
            norm_res = '0;
        end else if (exp_n[E+1] || exp_n == '0) begin
            norm_res = '0;
            norm_unf = 1'b1;
        end else if (exp_n >= (E+2)'(EXP_MAX)) begin
            norm_res = {a_sign_q, {E{1'b1}}, {M{1'b0}}};
            norm_ovf = 1'b1;
        end else begin
            norm_res = {a_sign_q, exp_n[E-1:0], mant_n};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ALIGN;
            end
            ALIGN: state_next = ADD;
            ADD:   state_next = NORM;
            NORM:  state_next = last_q ? OUT : IDLE;
            OUT: begin
                out_valid = 1'b1;
                out_data  = acc_q;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            last_q     <= 1'b0;
            acc_q      <= '0;
            first_q    <= 1'b1;
            a_sign_q   <= 1'b0;
            a_exp_q    <= '0;
            a_mant_q   <= '0;
            b_mant_q   <= '0;
            sub_q      <= 1'b0;
            inf_q      <= 1'b0;
            inf_sign_q <= 1'b0;
            sum_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q   <= in_data;
                        last_q <= in_last;
                    end
                end
                ALIGN: begin
                    a_sign_q   <= a_u.sign;
                    a_exp_q    <= a_u.exp;
                    a_mant_q   <= a_u.mant;
                    b_mant_q   <= b_aligned;
                    sub_q      <= a_u.sign ^ b_u.sign;
                    inf_q      <= op_inf | acc_inf;
                    inf_sign_q <= inf_sign;
                end
                ADD: begin
                    if (sub_q) sum_q <= {1'b0, a_mant_q, {G{1'b0}}} - {1'b0, b_mant_q};
                    else       sum_q <= {1'b0, a_mant_q, {G{1'b0}}} + {1'b0, b_mant_q};
                end
                NORM: begin
                    acc_q   <= norm_res;
                    first_q <= 1'b0;
                end
                OUT: begin
                    if (out_ready) begin
                        acc_q   <= '0;
                        first_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FLOAT_ACC_FLAGS_EN
    logic [1:0] flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (state == NORM) begin
            flags_q <= flags_q | {norm_ovf, norm_unf};
        end else if (state == OUT && out_ready) begin
            flags_q <= '0;
        end
    end

    assign flags = flags_q;
`else
    logic flags_unused;
    assign flags_unused = norm_ovf ^ norm_unf;
`endif

endmodule

// File: tb/tb_float_acc.sv
// Self-checking bench for float_acc: directed vector table, multi-cycle corner
// sequences and random frames checked against an integer-arithmetic model.
module tb_float_acc;
    import float_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
`ifdef FLOAT_ACC_FLAGS_EN
    logic [1:0]  flags;
    logic [1:0]  expf_q[$];
`endif

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    float_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FLOAT_ACC_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
    } ref_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        two;
        logic [31:0] sum;
        logic [1:0]  fl;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Sum of two floats from the arithmetic rules: B is truncated onto A's
    // grid (2^(eA-26)), magnitudes added exactly, result truncated to 24 bits.
    function automatic ref_t ref_add(input logic [31:0] acc, input logic [31:0] op);
        ref_t r;
        int ea, eb, e, d;
        longint ma, mb, a, b, s;
        logic sa, sb;
        r.res = '0;
        r.ovf = 1'b0;
        r.unf = 1'b0;
        if (op[30:23] == 8'hFF) begin
            r.res = (acc[30:23] == 8'hFF && acc[31] != op[31]) ? 32'h7F800000 : {op[31], 8'hFF, 23'h0};
            return r;
        end
        if (acc[30:23] == 8'hFF) begin
            r.res = {acc[31], 8'hFF, 23'h0};
            return r;
        end
        ea = int'(acc[30:23]); sa = acc[31];
        ma = (ea == 0) ? 64'd0 : ((64'd1 << 23) | longint'(acc[22:0]));
        eb = int'(op[30:23]);  sb = op[31];
        mb = (eb == 0) ? 64'd0 : ((64'd1 << 23) | longint'(op[22:0]));
        if (eb > ea || (eb == ea && mb > ma)) begin
            e = ea; ea = eb; eb = e;
            s = ma; ma = mb; mb = s;
            sa = op[31]; sb = acc[31];
        end
        d = ea - eb;
        a = ma * 8;
        b = (d >= 27) ? 64'd0 : ((mb * 8) >> d);
        s = (sa == sb) ? a + b : a - b;
        if (s == 0) return r;
        e = ea;
        while (s >= (64'd1 << 27)) begin s = s >> 1; e++; end
        while (s <  (64'd1 << 26)) begin s = s << 1; e--; end
        if (e >= 2 * BIAS + 1) begin
            r.ovf = 1'b1;
            r.res = {sa, 8'hFF, 23'h0};
        end else if (e <= 0) begin
            r.unf = 1'b1;
        end else begin
            r.res = {sa, 8'(e), 23'(s >> 3)};
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        if ($urandom_range(0, 9) == 0) return {1'($urandom_range(0, 1)), 31'h0};
        e = 8'($urandom_range(115, 140));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // Returns one time unit after the accepting edge.
    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic recv(input string name);
        int n = 0;
        logic [31:0] e;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!out_valid || exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_timeout actual=out_valid_%0d required=out_valid_1", name, out_valid);
            return;
        end
        e = exp_q.pop_front();
        check({name, "_sum"}, out_data, e);
`ifdef FLOAT_ACC_FLAGS_EN
        check({name, "_flags"}, 32'(flags), 32'(expf_q.pop_front()));
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({name, "_ready_after"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic expect_frame(input logic [31:0] s, input logic [1:0] f);
        exp_q.push_back(s);
`ifdef FLOAT_ACC_FLAGS_EN
        expf_q.push_back(f);
`else
        if (f > 2'd3) $display("unreachable");
`endif
    endtask

    vec_t vecs[9];

    initial begin
        int n;
        vecs[0] = '{32'h3F800000, 32'h40000000, 1'b1, 32'h40400000, 2'b00};
        vecs[1] = '{32'h3F800000, 32'hBF800000, 1'b1, 32'h00000000, 2'b00};
        vecs[2] = '{32'h3F800000, 32'h30800000, 1'b1, 32'h3F800000, 2'b00};
        vecs[3] = '{32'hC0A00000, 32'h00000000, 1'b0, 32'hC0A00000, 2'b00};
        vecs[4] = '{32'h40000000, 32'h00000000, 1'b0, 32'h40000000, 2'b00};
        vecs[5] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000, 2'b10};
        vecs[6] = '{32'h00800000, 32'h80C00000, 1'b1, 32'h00000000, 2'b01};
        vecs[7] = '{32'h40000000, 32'hB3800000, 1'b1, 32'h3FFFFFFF, 2'b00};
        vecs[8] = '{32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 2'b00};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: in_ready back on the 4th cycle, out_valid on the 4th cycle
        send(32'h3F800000, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready && n < 20);
        check("in_ready_latency", 32'(n), 32'd4);
        expect_frame(32'h40400000, 2'b00);
        send(32'h40000000, 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        check("out_valid_latency", 32'(n), 32'd4);
        recv("latency");

        for (int i = 0; i < 9; i++) begin
            expect_frame(vecs[i].sum, vecs[i].fl);
            send(vecs[i].a, !vecs[i].two);
            if (vecs[i].two) send(vecs[i].b, 1'b1);
            recv($sformatf("vec%0d", i));
        end

        // Back-pressure in OUT: outputs hold, in_valid pulses ignored
        send(32'h40000000, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_out_data", out_data, 32'h40000000);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            in_data  = 32'h3F800000;
            in_last  = 1'b1;
            in_valid = (i % 2 == 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("hold_release_in_ready", {31'b0, in_ready}, 32'd1);
        check("hold_release_out_valid", {31'b0, out_valid}, 32'd0);
        expect_frame(32'h3F800000, 2'b00);
        send(32'h3F800000, 1'b1);
        recv("after_hold");

        // Reset during ALIGN of a frame's 2nd operand
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_out_data", out_data, 32'd0);
`ifdef FLOAT_ACC_FLAGS_EN
        check("midrst_flags", 32'(flags), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_frame(32'h40400000, 2'b00);
        send(32'h40400000, 1'b1);
        recv("after_reset");

        // Random frames against the reference model
        for (int f = 0; f < 40; f++) begin
            int len;
            logic [31:0] acc;
            logic [31:0] ops[4];
            logic [1:0] fl;
            ref_t r;
            len = $urandom_range(1, 4);
            acc = '0;
            fl  = '0;
            for (int k = 0; k < len; k++) begin
                ops[k] = rand_op();
                if (k > 0 && $urandom_range(0, 5) == 0) ops[k] = {~ops[k-1][31], ops[k-1][30:0]};
                r   = ref_add(acc, ops[k]);
                acc = r.res;
                fl  = fl | {r.ovf, r.unf};
            end
            expect_frame(acc, fl);
            for (int k = 0; k < len; k++) send(ops[k], k == len - 1);
            recv($sformatf("rand%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/float_acc.md
Name: float_acc

Overview:
- Sequential IEEE-754 single-precision accumulator that sits directly downstream of float_mul.
- Consumes a stream of products over a valid/ready handshake and sums them into a running total.
- Emits the total when the operand flagged "last" has been added.
- Forms the accumulate half of the team's dot-product / MAC datapath.

Parameters:
E, 8, exponent width
M, 23, stored mantissa width
Width, 32, total float width (1 + E + M)
G, 3, extra low-order alignment bits kept below the mantissa LSB

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand present
in_ready  output  1  block can accept an operand
in_data  input  Width  float operand (typically a float_mul product)
in_last  input  1  operand is the final one of the current frame
out_valid  output  1  frame sum available
out_ready  input  1  consumer accepts the sum
out_data  output  Width  frame sum

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state=IDLE, accumulator=+0, first flag=1.
  - in_ready=1, out_valid=0, out_data=0.
  - Reset mid-operation discards the in-flight operand and the partial sum.
- FSM states: IDLE, ALIGN, ADD, NORM, OUT.
  - IDLE: in_ready=1. On in_valid&in_ready, register in_data and in_last, then go to ALIGN. in_ready=0 in every other state.
  - ALIGN: unpack both the operand and the accumulator, with hidden bit = (exp!=0).
    - exp==0 is flushed to zero; there is no denormal support.
    - When first=1, the accumulator is treated as +0.
    - Swap so the larger magnitude is operand A.
    - Right-shift B by (eA-eB) into a (M+1+G)-bit field. Bits shifted past G are dropped, so a shift >= M+1+G makes B=0.
  - ADD: same signs add magnitudes; different signs subtract B from A. The sum is M+2+G bits; the sign is A's sign.
  - NORM:
    - Carry out: shift right 1, exp+1.
    - Otherwise: leading-zero count, shift left, exp-lz.
    - Truncate the G bits (round toward zero, matching float_mul).
    - A zero magnitude result gives +0.
    - Exponent >= 255 saturates to ±inf (exp=all ones, mant=0).
    - Exponent <= 0 flushes to +0.
    - Write the accumulator and clear first.
    - Next state is OUT if the latched in_last=1, else IDLE.
  - OUT: out_valid=1, out_data=accumulator, both held stable while out_ready=0. On out_ready: go to IDLE, accumulator=+0, first=1, out_valid=0.
- Timing:
  - Acceptance to accumulator update: 3 cycles (ALIGN, ADD, NORM).
  - in_ready reasserts on the 4th cycle after acceptance, giving a throughput of 1 operand per 4 cycles.
  - out_valid rises the cycle after NORM of the last operand.
- Special inputs:
  - An operand whose exponent is all ones is treated as ±inf: the result becomes inf of that sign.
  - Inf plus opposite-sign inf gives +inf. No NaN is generated.
- Simultaneous events: in_valid during OUT is ignored because in_ready=0. out_ready outside OUT is ignored.

Optional Feature:
- FLOAT_ACC_FLAGS_EN defined:
  - Adds output port flags [1:0] = {ovf, unf}.
  - ovf is set when NORM saturates to inf. unf is set when NORM flushes a nonzero result to zero.
  - Flags are sticky across the frame, valid with out_valid, and cleared on the out handshake and on reset.
- Undefined: the port and logic are absent; saturation and flush behaviour are unchanged.

Decomposition:
- Package float_pkg:
  - Constants E, M, Width, BIAS=127, EXP_MAX=255.
  - Unpacked-float struct {sign, exp[E-1:0], mant[M:0]}.
  - FSM state enum.
- One sub-module, float_acc_lzc: a combinational leading-zero counter over M+2+G bits, used in NORM.

Test Plan:
- 0x3F800000 (1.0), then 0x40000000 (2.0, last) -> out_data=0x40400000 (3.0); out_valid 4 cycles after the 2nd accept.
- 0x3F800000, then 0xBF800000 (last) -> out_data=0x00000000; 0x3F800000, then 0x30800000 (2^-30, last) -> 0x3F800000 (truncated).
- Single operand 0xC0A00000 with last=1 -> out_data=0xC0A00000; a following frame of 0x40000000 (last) -> 0x40000000, proving the accumulator clears between frames.
- 0x7F7FFFFF, then 0x7F7FFFFF (last) -> 0x7F800000; with FLOAT_ACC_FLAGS_EN, flags=2'b10.
- Hold out_ready=0 for 5 cycles in OUT -> out_valid and out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
- Assert rst_n=0 during ALIGN of the 2nd operand of a frame -> outputs take reset values immediately; a new frame 0x40400000 (last) -> 0x40400000.
